branch_predictor_btb: RTL

//  Direct-mapped branch target buffer plus 2-bit saturating pattern history table for the pipelined RV32 core.

---
 rtl/branch_predictor_btb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit PHT for the RV32 fetch stage.
// Optional gshare history indexing is enabled with `define GSHARE_EN.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            resolve_valid,
  input  logic            resolve_is_jump,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic [XLEN-1:0] resolve_target,
  input  logic            resolve_pred_taken,
  input  logic [XLEN-1:0] resolve_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     lookup_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TLO   = IDX_W + 2;
  localparam int THI   = IDX_W + 1 + TAG_W;
  localparam int unused_ghr_w = GHR_W;

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0][1:0] pht_q, pht_d;
  logic [TAG_W-1:0]        tag_q [ENTRIES];
  logic                    jmp_q [ENTRIES];
  logic [XLEN-1:0]         tgt_q [ENTRIES];
  logic [31:0]             lookup_q, lookup_d;
  logic [31:0]             misp_q, misp_d;

  logic [IDX_W-1:0] f_idx, f_pidx, r_idx, r_pidx;
  logic [TAG_W-1:0] f_tag, r_tag;
  logic             r_hit, wr_en;
  logic [1:0]       r_ctr;
  logic             unused_pc;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[THI:TLO];
  assign r_idx = resolve_pc[IDX_W+1:2];
  assign r_tag = resolve_pc[THI:TLO];
  assign unused_pc = ^{fetch_pc, resolve_pc};

`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  assign f_pidx = f_idx ^ IDX_W'(ghr_q);
  assign r_pidx = r_idx ^ IDX_W'(ghr_q);

  // History shifts in each resolving conditional branch outcome
  always_comb begin
    ghr_d = ghr_q;
    if (resolve_valid && !resolve_is_jump)
      ghr_d = {ghr_q[GHR_W-2:0], resolve_taken};
  end

  // History register, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  assign f_pidx = f_idx;
  assign r_pidx = r_idx;
`endif

  // Fetch lookup reads pre-update state: no write bypass
  always_comb begin
    pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = pred_hit && (jmp_q[f_idx] || pht_q[f_pidx][1]);
    pred_target = pred_taken ? tgt_q[f_idx] : fetch_pc + XLEN'(4);
  end

  // Resolution check: wrong direction, or taken to the wrong place
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    if (resolve_valid) begin
      mispredict = (resolve_taken != resolve_pred_taken) ||
                   (resolve_taken &&
                    (resolve_target != resolve_pred_target));
      redirect_pc = resolve_taken ? resolve_target
                                  : resolve_pc + XLEN'(4);
    end
  end

  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign r_ctr = pht_q[r_pidx];

  // Training: saturating PHT step, allocate or refresh on taken
  always_comb begin
    valid_d = valid_q;
    pht_d   = pht_q;
    wr_en   = 1'b0;
    if (resolve_valid) begin
      if (!resolve_is_jump) begin
        if (resolve_taken)
          pht_d[r_pidx] = (r_ctr == 2'b11) ? r_ctr : r_ctr + 2'd1;
        else
          pht_d[r_pidx] = (r_ctr == 2'b00) ? r_ctr : r_ctr - 2'd1;
      end
      if (resolve_taken) begin
        wr_en = 1'b1;
        if (!r_hit) begin
          valid_d[r_idx] = 1'b1;
          if (!resolve_is_jump) pht_d[r_pidx] = 2'b10;
        end
      end
    end
  end

  // Saturating statistics
  always_comb begin
    lookup_d = lookup_q;
    misp_d   = misp_q;
    if (fetch_valid && lookup_q != '1) lookup_d = lookup_q + 32'd1;
    if (mispredict && misp_q != '1)    misp_d   = misp_q + 32'd1;
  end

  // Valid bits, PHT and counters with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      pht_q    <= '0;
      lookup_q <= '0;
      misp_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pht_q    <= pht_d;
      lookup_q <= lookup_d;
      misp_q   <= misp_d;
    end
  end

  // Entry payload; only meaningful while the valid bit is set
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[r_idx] <= r_tag;
      jmp_q[r_idx] <= resolve_is_jump;
      tgt_q[r_idx] <= resolve_target;
    end
  end

  assign lookup_count     = lookup_q;
  assign mispredict_count = misp_q;

endmodule
